// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, decode enums and the packed control bundle handed from decode to execute.
package rv32i_pkg;

  localparam int REG_SIZE  = 32;
  localparam int REG_WIDTH = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
  } ctrl_t;

  // alt selects SUB/SRA; callers only raise it where the encoding allows it
  function automatic alu_op_e funct_to_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for the RV32I instruction formats.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7]         instr_hi,
  input  imm_sel_e            imm_sel,
  output logic [REG_SIZE-1:0] imm
);

  // format-dependent bit shuffle; formats without an immediate yield zero
  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I:   imm = {{20{instr_hi[31]}}, instr_hi[31:20]};
      IMM_S:   imm = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
      IMM_B:   imm = {{20{instr_hi[31]}}, instr_hi[7], instr_hi[30:25], instr_hi[11:8], 1'b0};
      IMM_U:   imm = {instr_hi[31:12], 12'b0};
      IMM_J:   imm = {{12{instr_hi[31]}}, instr_hi[19:12], instr_hi[20], instr_hi[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode: register-file addressing with writeback bypass, control/immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage
  import rv32i_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_valid,
  input  logic [31:0]          if_instr,
  input  logic [REG_SIZE-1:0]  if_pc,
  output logic                 id_ready,
  output logic [REG_WIDTH-1:0] rs1_addr,
  output logic [REG_WIDTH-1:0] rs2_addr,
  input  logic [REG_SIZE-1:0]  rs1_read,
  input  logic [REG_SIZE-1:0]  rs2_read,
  input  logic                 wb_we,
  input  logic [REG_WIDTH-1:0] wb_addr,
  input  logic [REG_SIZE-1:0]  wb_data,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [REG_SIZE-1:0]  ex_pc,
  output logic [REG_SIZE-1:0]  ex_rs1_data,
  output logic [REG_SIZE-1:0]  ex_rs2_data,
  output logic [REG_SIZE-1:0]  ex_imm,
  output logic [REG_WIDTH-1:0] ex_rd,
  output ctrl_t                ex_ctrl,
  output logic                 ex_illegal
);

  logic [6:0]           opcode_s, funct7_s;
  logic [2:0]           funct3_s;
  logic [REG_WIDTH-1:0] rd_s;
  ctrl_t                ctrl_s;
  imm_sel_e             imm_sel_s;
  logic                 illegal_s, use_rs1_s, use_rs2_s, hz_s, transfer_s;
  logic [REG_SIZE-1:0]  imm_s, rs1_data_s, rs2_data_s;

  logic                 ex_valid_d, ex_valid_q, ex_illegal_d, ex_illegal_q;
  logic [REG_SIZE-1:0]  ex_pc_d, ex_pc_q, ex_rs1_d, ex_rs1_q, ex_rs2_d, ex_rs2_q, ex_imm_d, ex_imm_q;
  logic [REG_WIDTH-1:0] ex_rd_d, ex_rd_q;
  ctrl_t                ex_ctrl_d, ex_ctrl_q;

  assign opcode_s = if_instr[6:0];
  assign rd_s     = if_instr[11:7];
  assign funct3_s = if_instr[14:12];
  assign funct7_s = if_instr[31:25];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  imm_gen u_imm_gen (
    .instr_hi (if_instr[31:7]),
    .imm_sel  (imm_sel_s),
    .imm      (imm_s)
  );

  // opcode/funct decode into control, immediate format and which sources are really read
  always_comb begin
    ctrl_s        = '0;
    ctrl_s.alu_op = ALU_ADD;
    ctrl_s.funct3 = funct3_s;
    imm_sel_s     = IMM_NONE;
    illegal_s     = 1'b0;
    use_rs1_s     = 1'b0;
    use_rs2_s     = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        imm_sel_s = IMM_U; ctrl_s.alu_op = ALU_PASS_B; ctrl_s.alu_src_imm = 1'b1; ctrl_s.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel_s = IMM_U; ctrl_s.alu_src_imm = 1'b1; ctrl_s.alu_src_pc = 1'b1; ctrl_s.reg_write = 1'b1;
      end
      OPC_JAL: begin
        imm_sel_s = IMM_J; ctrl_s.alu_src_pc = 1'b1; ctrl_s.jump = 1'b1; ctrl_s.reg_write = 1'b1;
      end
      OPC_JALR: begin
        imm_sel_s = IMM_I; use_rs1_s = 1'b1; ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.jump = 1'b1; ctrl_s.reg_write = 1'b1; illegal_s = (funct3_s != 3'b000);
      end
      OPC_BRANCH: begin
        imm_sel_s = IMM_B; use_rs1_s = 1'b1; use_rs2_s = 1'b1; ctrl_s.alu_op = ALU_SUB;
        ctrl_s.branch = 1'b1; illegal_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
      end
      OPC_LOAD: begin
        imm_sel_s = IMM_I; use_rs1_s = 1'b1; ctrl_s.alu_src_imm = 1'b1; ctrl_s.mem_read = 1'b1;
        ctrl_s.reg_write = 1'b1;
        illegal_s = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111);
      end
      OPC_STORE: begin
        imm_sel_s = IMM_S; use_rs1_s = 1'b1; use_rs2_s = 1'b1; ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.mem_write = 1'b1; illegal_s = (funct3_s > 3'b010);
      end
      OPC_OPIMM: begin
        imm_sel_s = IMM_I; use_rs1_s = 1'b1; ctrl_s.alu_src_imm = 1'b1; ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_op = funct_to_alu(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
        illegal_s = ((funct3_s == 3'b001) && (funct7_s != 7'h00)) ||
                    ((funct3_s == 3'b101) && (funct7_s != 7'h00) && (funct7_s != 7'h20));
      end
      OPC_OP: begin
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_op = funct_to_alu(funct3_s, funct7_s[5]);
        illegal_s = !((funct7_s == 7'h00) ||
                      ((funct7_s == 7'h20) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
      end
      OPC_FENCE: ctrl_s.alu_op = ALU_ADD;
      default:   illegal_s = 1'b1;
    endcase
    // an illegal instruction must have no architectural side effects downstream
    ctrl_s.reg_write = ctrl_s.reg_write && !illegal_s && (rd_s != 5'd0);
    ctrl_s.mem_read  = ctrl_s.mem_read  && !illegal_s;
    ctrl_s.mem_write = ctrl_s.mem_write && !illegal_s;
    ctrl_s.branch    = ctrl_s.branch    && !illegal_s;
    ctrl_s.jump      = ctrl_s.jump      && !illegal_s;
    use_rs1_s        = use_rs1_s && !illegal_s;
    use_rs2_s        = use_rs2_s && !illegal_s;
  end

  assign rs1_data_s = (rs1_addr == 5'd0) ? '0 :
                      (wb_we && (wb_addr == rs1_addr)) ? wb_data : rs1_read;
  assign rs2_data_s = (rs2_addr == 5'd0) ? '0 :
                      (wb_we && (wb_addr == rs2_addr)) ? wb_data : rs2_read;

  assign hz_s = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != 5'd0) &&
                ((use_rs1_s && (ex_rd_q == rs1_addr)) || (use_rs2_s && (ex_rd_q == rs2_addr)));
  assign id_ready   = flush || ((!ex_valid_q || ex_ready) && !hz_s);
  assign transfer_s = if_valid && id_ready;

  // ID/EX next state: flush beats load, load beats drain, otherwise hold for stall
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_illegal_d = ex_illegal_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (transfer_s) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = if_pc;
      ex_rs1_d     = rs1_data_s;
      ex_rs2_d     = rs2_data_s;
      ex_imm_d     = imm_s;
      ex_rd_d      = rd_s;
      ex_ctrl_d    = ctrl_s;
      ex_illegal_d = illegal_s;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      ex_ctrl_q    <= '0;
      ex_illegal_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1_data = ex_rs1_q;
  assign ex_rs2_data = ex_rs2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rd       = ex_rd_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_illegal  = ex_illegal_q;

endmodule
